// File: rtl/hex_scroll_if.sv
// Bundle of the switch/key inputs and HEX display outputs of hex_scroll_ctrl.
// master drives the message and controls; slave is the scroll controller.
interface hex_scroll_if #(
    parameter int NUM_DISP = 8,
    parameter int MSG_LEN  = 8,
    parameter int POS_W    = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
);
    logic [3*MSG_LEN-1:0]    msg;
    logic                    load;
    logic                    run;
    logic                    dir;
    logic                    step;
    logic [POS_W-1:0]        pos;
    logic                    step_tick;
    logic [NUM_DISP-1:0][6:0] hex_disp;

    modport master (
        output msg, load, run, dir, step,
        input  pos, step_tick, hex_disp
    );

    modport slave (
        input  msg, load, run, dir, step,
        output pos, step_tick, hex_disp
    );
endinterface

// File: rtl/hex_scroll_ctrl.sv
// Scrolling message window on active-low seven-segment digits.
// A MSG_LEN buffer of 3-bit character codes is shown NUM_DISP digits at a
// time starting at pos; pos advances on a prescaled tick (run=1) or on each
// rising edge of the step key (run=0), forward or reverse per dir.
module hex_scroll_ctrl #(
    parameter int NUM_DISP = 8,
    parameter int MSG_LEN  = 8,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic         clk,
    input  logic         rst,
    hex_scroll_if.slave  bus
);
    localparam int POS_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int PS_W  = $clog2(TICK_DIV);

    typedef enum logic {ST_STATIC, ST_SCROLL} state_e;

    state_e                   state_q;
    logic [PS_W-1:0]          presc_q;
    logic [POS_W-1:0]         pos_q;
    logic [POS_W-1:0]         pos_d;
    logic [MSG_LEN-1:0][2:0]  buf_q;
    logic                     step_q;
    logic                     tick_q;
    logic [NUM_DISP-1:0][6:0] hex_q;
    logic [NUM_DISP-1:0][6:0] hex_d;
    logic [POS_W-1:0]         idx;
    logic                     step_rise;

    function automatic logic [6:0] seg_decode(input logic [2:0] c);
        case (c)
            3'd0:    seg_decode = 7'b0100001; // d
            3'd1:    seg_decode = 7'b0000110; // E
            3'd2:    seg_decode = 7'b1111001; // 1
            3'd3:    seg_decode = 7'b1000000; // 0
            3'd4:    seg_decode = 7'b0100100; // 2
            default: seg_decode = 7'b1111111; // blank
        endcase
    endfunction

    assign step_rise = bus.step & ~step_q;

    // Position after one advance in the current direction, wrapping at the ends
    always_comb begin
        pos_d = pos_q;
        if (bus.dir) begin
            pos_d = (pos_q == '0) ? POS_W'(MSG_LEN - 1) : pos_q - 1'b1;
        end else begin
            pos_d = (pos_q == POS_W'(MSG_LEN - 1)) ? '0 : pos_q + 1'b1;
        end
    end

    // Control FSM: load, prescaler, manual step and position update
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_STATIC;
            presc_q <= '0;
            pos_q   <= '0;
            buf_q   <= {MSG_LEN{3'h7}};
            step_q  <= 1'b1;   // a key held through reset is not an edge
            tick_q  <= 1'b0;
        end else begin
            // Edge register always tracks, so SCROLL never queues a step.
            step_q  <= bus.step;
            tick_q  <= 1'b0;
            state_q <= bus.run ? ST_SCROLL : ST_STATIC;
            if (bus.load) begin
                buf_q   <= bus.msg;
                pos_q   <= '0;
                presc_q <= '0;
            end else begin
                case (state_q)
                    ST_STATIC: begin
                        presc_q <= '0;
                        if (!bus.run && step_rise) begin
                            pos_q  <= pos_d;
                            tick_q <= 1'b1;
                        end
                    end
                    ST_SCROLL: begin
                        if (!bus.run) begin
                            presc_q <= '0;
                        end else if (presc_q == PS_W'(TICK_DIV - 1)) begin
                            presc_q <= '0;
                            pos_q   <= pos_d;
                            tick_q  <= 1'b1;
                        end else begin
                            presc_q <= presc_q + 1'b1;
                        end
                    end
                    default: presc_q <= '0;
                endcase
            end
        end
    end

    // Window of the buffer starting at pos, wrapping around the message end
    always_comb begin
        idx   = '0;
        hex_d = '1;
        for (int i = 0; i < NUM_DISP; i++) begin
            idx      = POS_W'((int'(pos_q) + i) % MSG_LEN);
            hex_d[i] = seg_decode(buf_q[idx]);
        end
    end

    // Registered segment outputs, one cycle behind pos/buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            hex_q <= {NUM_DISP{7'h7F}};
        end else begin
            hex_q <= hex_d;
        end
    end

    assign bus.pos       = pos_q;
    assign bus.step_tick = tick_q;
    assign bus.hex_disp  = hex_q;
endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Bench for hex_scroll_ctrl: directed vector table, hand-written corner
// sequences and random stimulus against a cycle-level reference model,
// on an 8-char and a 3-char instance sharing the same controls.
module tb_hex_scroll_ctrl;
    localparam int TD = 4;
    localparam logic [6:0] SD  = 7'b0100001;
    localparam logic [6:0] SE  = 7'b0000110;
    localparam logic [6:0] S1  = 7'b1111001;
    localparam logic [6:0] S0  = 7'b1000000;
    localparam logic [6:0] S2  = 7'b0100100;
    localparam logic [6:0] SBL = 7'h7F;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, load = 1'b0, run = 1'b0, dir = 1'b0, step = 1'b1;
    logic [23:0] msg_a = '0;
    logic [8:0]  msg_b = '0;
    int n_assert = 0;
    int n_fail   = 0;

    hex_scroll_if #(.NUM_DISP(8), .MSG_LEN(8)) ifa ();
    hex_scroll_if #(.NUM_DISP(8), .MSG_LEN(3)) ifb ();

    assign ifa.msg = msg_a; assign ifa.load = load; assign ifa.run = run;
    assign ifa.dir = dir;   assign ifa.step = step;
    assign ifb.msg = msg_b; assign ifb.load = load; assign ifb.run = run;
    assign ifb.dir = dir;   assign ifb.step = step;

    hex_scroll_ctrl #(.NUM_DISP(8), .MSG_LEN(8), .TICK_DIV(TD)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    hex_scroll_ctrl #(.NUM_DISP(8), .MSG_LEN(3), .TICK_DIV(TD)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    // Reference model state: window start, tick counter, message, display
    typedef struct packed {
        logic [31:0]      pos;
        logic [31:0]      cnt;
        logic             scroll;
        logic             prev;
        logic             tick;
        logic [15:0][2:0] chars;
        logic [7:0][6:0]  hex;
    } mdl_t;

    mdl_t ma = '0, mb = '0;

    function automatic logic [6:0] seg(input logic [2:0] c);
        case (c)
            3'd0: return SD;
            3'd1: return SE;
            3'd2: return S1;
            3'd3: return S0;
            3'd4: return S2;
            default: return SBL;
        endcase
    endfunction

    function automatic mdl_t mstep(input mdl_t s, input int ml, input logic r, input logic l,
                                   input logic ru, input logic d, input logic st, input logic [47:0] m);
        mdl_t n = s;
        logic adv = 1'b0;
        for (int i = 0; i < 8; i++) n.hex[i] = seg(s.chars[(int'(s.pos) + i) % ml]);
        n.tick = 1'b0;
        if (r) begin
            n.pos = 0; n.cnt = 0; n.scroll = 1'b0; n.prev = 1'b1;
            n.chars = '1; n.hex = '1;
            return n;
        end
        n.prev   = st;
        n.scroll = ru;
        if (l) begin
            for (int k = 0; k < ml; k++) n.chars[k] = m[3*k +: 3];
            n.pos = 0; n.cnt = 0;
            return n;
        end
        if (!s.scroll) begin
            n.cnt = 0;
            adv = !ru && st && !s.prev;
        end else if (!ru) begin
            n.cnt = 0;
        end else if (int'(s.cnt) == TD - 1) begin
            n.cnt = 0;
            adv = 1'b1;
        end else begin
            n.cnt = s.cnt + 1;
        end
        if (adv) n.pos = d ? (int'(s.pos) + ml - 1) % ml : (int'(s.pos) + 1) % ml;
        n.tick = adv;
        return n;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock: model follows the inputs seen at the edge, outputs checked at negedge
    task automatic cyc();
        @(posedge clk);
        ma = mstep(ma, 8, rst, load, run, dir, step, 48'(msg_a));
        mb = mstep(mb, 3, rst, load, run, dir, step, 48'(msg_b));
        @(negedge clk);
        chk("A.pos",  64'(ifa.pos),       64'(ma.pos));
        chk("A.tick", 64'(ifa.step_tick), 64'(ma.tick));
        chk("A.hex",  64'(ifa.hex_disp),  64'(ma.hex));
        chk("B.pos",  64'(ifb.pos),       64'(mb.pos));
        chk("B.tick", 64'(ifb.step_tick), 64'(mb.tick));
        chk("B.hex",  64'(ifb.hex_disp),  64'(mb.hex));
    endtask

    typedef struct {
        logic r, l, ru, d, s;
        int   pos;
        logic tick;
        logic hchk;
        logic [6:0] h0, h1;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t v(input logic r, l, ru, d, s, input int p, input logic t,
                               input logic hc, input logic [6:0] a, input logic [6:0] b);
        vec_t x;
        x.r = r; x.l = l; x.ru = ru; x.d = d; x.s = s;
        x.pos = p; x.tick = t; x.hchk = hc; x.h0 = a; x.h1 = b;
        return x;
    endfunction

    initial begin
        logic [23:0] msg_main;
        msg_main = {3'd7, 3'd7, 3'd7, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

        //             r  l  ru d  s  pos t  hc  h0   h1
        vt.push_back(v(1, 0, 0, 0, 1, 0, 0, 1, SBL, SBL)); // reset, key held
        vt.push_back(v(1, 0, 0, 0, 1, 0, 0, 1, SBL, SBL));
        vt.push_back(v(0, 0, 0, 0, 1, 0, 0, 1, SBL, SBL)); // release: no advance
        vt.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, SBL, SBL));
        vt.push_back(v(0, 1, 0, 0, 1, 0, 0, 1, SBL, SBL)); // load
        vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, SD,  SE));
        vt.push_back(v(0, 0, 0, 0, 1, 1, 1, 1, SD,  SE));  // key edge
        vt.push_back(v(0, 0, 0, 0, 1, 1, 0, 1, SE,  S1));
        vt.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, SBL, SBL));
        vt.push_back(v(0, 0, 1, 0, 0, 1, 0, 0, SBL, SBL)); // run on
        vt.push_back(v(0, 0, 1, 0, 0, 1, 0, 0, SBL, SBL));
        vt.push_back(v(0, 0, 1, 0, 0, 1, 0, 0, SBL, SBL));
        vt.push_back(v(0, 0, 1, 0, 0, 1, 0, 0, SBL, SBL));
        vt.push_back(v(0, 0, 1, 0, 0, 2, 1, 1, SE,  S1));  // 4th scroll cycle
        vt.push_back(v(0, 0, 1, 0, 0, 2, 0, 1, S1,  S0));
        vt.push_back(v(0, 0, 1, 0, 0, 2, 0, 0, SBL, SBL));
        vt.push_back(v(0, 0, 1, 0, 0, 2, 0, 0, SBL, SBL));
        vt.push_back(v(0, 1, 1, 0, 0, 0, 0, 0, SBL, SBL)); // load on terminal count
        vt.push_back(v(0, 0, 1, 0, 0, 0, 0, 1, SD,  SE));
        vt.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, SBL, SBL));
        vt.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, SBL, SBL));
        vt.push_back(v(0, 0, 1, 0, 0, 1, 1, 0, SBL, SBL)); // 4 cycles after load
        vt.push_back(v(0, 0, 1, 1, 0, 1, 0, 0, SBL, SBL)); // reverse
        vt.push_back(v(0, 0, 1, 1, 0, 1, 0, 0, SBL, SBL));
        vt.push_back(v(0, 0, 1, 1, 0, 1, 0, 0, SBL, SBL));
        vt.push_back(v(0, 0, 1, 1, 0, 0, 1, 0, SBL, SBL));
        vt.push_back(v(0, 0, 1, 1, 1, 0, 0, 0, SBL, SBL)); // key ignored in scroll
        vt.push_back(v(0, 0, 1, 1, 0, 0, 0, 0, SBL, SBL));
        vt.push_back(v(0, 0, 0, 1, 1, 0, 0, 0, SBL, SBL)); // run off, edge swallowed
        vt.push_back(v(0, 0, 0, 1, 1, 0, 0, 0, SBL, SBL));
        vt.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, SBL, SBL));
        vt.push_back(v(0, 0, 0, 1, 1, 7, 1, 0, SBL, SBL)); // manual reverse wrap
        vt.push_back(v(0, 0, 0, 1, 1, 7, 0, 1, SBL, SD));
        vt.push_back(v(0, 0, 0, 1, 0, 7, 0, 0, SBL, SBL));
        vt.push_back(v(0, 0, 0, 1, 1, 6, 1, 0, SBL, SBL));
        vt.push_back(v(0, 0, 0, 1, 0, 6, 0, 0, SBL, SBL));
        vt.push_back(v(0, 0, 0, 1, 1, 5, 1, 0, SBL, SBL));

        foreach (vt[k]) begin
            rst = vt[k].r; load = vt[k].l; run = vt[k].ru; dir = vt[k].d; step = vt[k].s;
            msg_a = msg_main; msg_b = msg_main[8:0];
            cyc();
            chk($sformatf("vec%0d.pos", k),  64'(ifa.pos),       64'(vt[k].pos));
            chk($sformatf("vec%0d.tick", k), 64'(ifa.step_tick), 64'(vt[k].tick));
            if (vt[k].hchk) begin
                chk($sformatf("vec%0d.h0", k), 64'(ifa.hex_disp[0]), 64'(vt[k].h0));
                chk($sformatf("vec%0d.h1", k), 64'(ifa.hex_disp[1]), 64'(vt[k].h1));
            end
        end

        // Full window after a load, and 3-char message wrapping across 8 digits
        rst = 0; run = 0; dir = 0; step = 0; load = 1;
        msg_a = msg_main; msg_b = {3'd3, 3'd2, 3'd1};
        cyc();
        load = 0;
        cyc();
        chk("A.window", 64'(ifa.hex_disp), 64'({SBL, SBL, SBL, S2, S0, S1, SE, SD}));
        chk("A.pos0",   64'(ifa.pos), 64'd0);
        chk("B.window", 64'(ifb.hex_disp), 64'({S1, SE, S0, S1, SE, S0, S1, SE}));
        step = 1;
        cyc();
        chk("B.step_tick", 64'(ifb.step_tick), 64'd1);
        cyc();
        chk("B.pos1",     64'(ifb.pos), 64'd1);
        chk("B.window1",  64'(ifb.hex_disp), 64'({S0, S1, SE, S0, S1, SE, S0, S1}));

        // Reset in the middle of scrolling; display stays blank until a load
        run = 1;
        repeat (6) cyc();
        rst = 1;
        cyc();
        chk("rst.pos",  64'(ifa.pos), 64'd0);
        chk("rst.tick", 64'(ifa.step_tick), 64'd0);
        chk("rst.hex",  64'(ifa.hex_disp), 64'({8{SBL}}));
        rst = 0;
        repeat (6) cyc();
        chk("post_rst.hex", 64'(ifa.hex_disp), 64'({8{SBL}}));

        // Random stimulus against the model
        for (int c = 0; c < 1500; c++) begin
            rst  = ($urandom_range(99) == 0);
            load = ($urandom_range(24) == 0);
            if ($urandom_range(29) == 0) run = ~run;
            if ($urandom_range(9) == 0)  dir = ~dir;
            if ($urandom_range(2) == 0)  step = ~step;
            msg_a = 24'($urandom);
            msg_b = 9'($urandom);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
